// File: rtl/wr_ptr_full.sv
// Write-side pointer, synchroniser and full/almost-full/level flags
// for the async FIFO, clocked entirely by wr_clk.
module wr_ptr_full #(
  parameter int ADDRSIZE     = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_en,
  input  logic [ADDRSIZE:0]   rd_ptr_gray,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic [ADDRSIZE:0]   wr_ptr_gray,
  output logic                wr_full,
  output logic                wr_afull,
  output logic [ADDRSIZE:0]   wr_count
);

  localparam int A = ADDRSIZE;
  localparam logic [A:0] THRESH = (A+1)'(AFULL_THRESH);

  logic [A:0] wr_bin;
  logic [A:0] rq1;
  logic [A:0] rq2;
  logic       push;
  logic [A:0] bin_next;
  logic [A:0] gray_next;
  logic [A:0] rd_bin_s;
  logic [A:0] level;
  logic [A:0] full_cmp;
  logic       full_next;
  logic       afull_next;

  function automatic logic [A:0] g2b(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Next pointer, fill level and flag terms from pre-edge state.
  always_comb begin
    push       = wr_en & ~wr_full;
    bin_next   = wr_bin + {{A{1'b0}}, push};
    gray_next  = (bin_next >> 1) ^ bin_next;
    rd_bin_s   = g2b(rq2);
    level      = bin_next - rd_bin_s;
    full_cmp   = {~rq2[A:A-1], rq2[A-2:0]};
    full_next  = (gray_next == full_cmp);
    afull_next = (level >= THRESH);
  end

  // Pointer, two-flop read-pointer synchroniser and flag registers.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      rq1         <= '0;
      rq2         <= '0;
      wr_full     <= 1'b0;
      wr_afull    <= 1'b0;
      wr_count    <= '0;
    end else begin
      wr_bin      <= bin_next;
      wr_ptr_gray <= gray_next;
      rq1         <= rd_ptr_gray;
      rq2         <= rq1;
      wr_full     <= full_next;
      wr_afull    <= afull_next;
      wr_count    <= level;
    end
  end

  assign wr_addr = wr_bin[A-1:0];

endmodule
